// File: rtl/three_op_pkg.sv
// Shared types for the three-operand sequencer: opcode and FSM state enums,
// result bundle and the add/subtract combiner used by the ALU.
package three_op_pkg;

  localparam int DW = 8;
  localparam int XW = 10;

  typedef enum logic [1:0] {
    OP_SUB_SUB = 2'b00,
    OP_SUB_ADD = 2'b01,
    OP_ADD_SUB = 2'b10,
    OP_ADD_ADD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    CAP_A,
    CAP_B,
    CAP_C,
    EXEC,
    HOLD
  } state_e;

  // Opcode bit 1 selects the sign of B, bit 0 the sign of C.
  function automatic logic [XW-1:0] combine(input op_e op, input logic [XW-1:0] a,
                                            input logic [XW-1:0] b, input logic [XW-1:0] c);
    logic [XW-1:0] ab;
    ab = (op == OP_ADD_SUB || op == OP_ADD_ADD) ? a + b : a - b;
    return (op == OP_SUB_ADD || op == OP_ADD_ADD) ? ab + c : ab - c;
  endfunction

endpackage

// File: rtl/three_op_alu.sv
// Combinational A (+/-) B (+/-) C in 10-bit arithmetic; zero latency, no handshake.
// Signed overflow output exists only when OVF_FLAG_EN is defined.
module three_op_alu
  import three_op_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  input  op_e           op_i,
  output logic [DW-1:0] r_o,
  output logic          wrap_o
`ifdef OVF_FLAG_EN
  , output logic        ovf_o
`endif
);

  logic [XW-1:0] xu;

  assign xu     = combine(op_i, {2'b00, a_i}, {2'b00, b_i}, {2'b00, c_i});
  assign r_o    = xu[DW-1:0];
  // Exact range is -510..765; anything outside 0..255 sets at least one of the top two bits.
  assign wrap_o = |xu[XW-1:DW];

`ifdef OVF_FLAG_EN
  logic signed [XW-1:0] xs;

  assign xs    = combine(op_i, {{2{a_i[DW-1]}}, a_i}, {{2{b_i[DW-1]}}, b_i},
                         {{2{c_i[DW-1]}}, c_i});
  assign ovf_o = (xs > 10'sd127) || (xs < -10'sd128);
`endif

endmodule

// File: rtl/three_op_sequencer.sv
// Collects A, B, C beats, then presents one result; out_valid rises two edges after the C beat.
// in_ready is low while a result is computed or held; result held until out_ready (OVF_FLAG_EN adds out_ovf).
module three_op_sequencer
  import three_op_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic          out_wrap
`ifdef OVF_FLAG_EN
  , output logic        out_ovf
`endif
);

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  op_e           op_q, op_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_r_q, out_r_d;
  logic          out_wrap_q, out_wrap_d;
  logic [DW-1:0] alu_r;
  logic          alu_wrap;
  logic          beat;

`ifdef OVF_FLAG_EN
  logic          out_ovf_q, out_ovf_d;
  logic          alu_ovf;
`endif

  three_op_alu u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .c_i    (c_q),
    .op_i   (op_q),
    .r_o    (alu_r),
    .wrap_o (alu_wrap)
`ifdef OVF_FLAG_EN
    , .ovf_o (alu_ovf)
`endif
  );

  assign in_ready = (state_q == CAP_A) || (state_q == CAP_B) || (state_q == CAP_C);
  assign beat     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_wrap_d  = out_wrap_q;
`ifdef OVF_FLAG_EN
    out_ovf_d   = out_ovf_q;
`endif
    unique case (state_q)
      CAP_A: if (beat) begin
        a_d     = in_data;
        op_d    = op_e'(in_op);
        state_d = CAP_B;
      end
      CAP_B: if (beat) begin
        b_d     = in_data;
        state_d = CAP_C;
      end
      CAP_C: if (beat) begin
        c_d     = in_data;
        state_d = EXEC;
      end
      EXEC: begin
        out_r_d    = alu_r;
        out_wrap_d = alu_wrap;
`ifdef OVF_FLAG_EN
        out_ovf_d  = alu_ovf;
`endif
        state_d    = HOLD;
      end
      // out_valid is a flop fed from HOLD, so it rises one cycle after the result settles.
      HOLD: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = CAP_A;
        end
      end
      default: state_d = CAP_A;
    endcase
    if (clr) begin
      state_d     = CAP_A;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CAP_A;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      op_q        <= OP_SUB_SUB;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_wrap_q  <= 1'b0;
`ifdef OVF_FLAG_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_wrap_q  <= out_wrap_d;
`ifdef OVF_FLAG_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_wrap  = out_wrap_q;
`ifdef OVF_FLAG_EN
  assign out_ovf   = out_ovf_q;
`endif

endmodule

// File: tb/tb_three_op_sequencer.sv
// Scoreboard bench for three_op_sequencer: expected results are queued when a set is issued
// and popped by an independent monitor on every output handshake.
module tb_three_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_wrap;
  logic [7:0] in_data, out_r;
  logic [1:0] in_op;
`ifdef OVF_FLAG_EN
  logic       out_ovf;
`endif

  typedef struct {
    logic [7:0] r;
    logic       wrap;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   rdy_rand = 0;

  always #5 clk = ~clk;

  three_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_wrap  (out_wrap)
`ifdef OVF_FLAG_EN
    , .out_ovf (out_ovf)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic straight from the opcode table.
  function automatic exp_t model(input int a, input int b, input int c, input logic [1:0] op);
    exp_t e;
    int   u, s, sa, sb, sc;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sc = (c > 127) ? c - 256 : c;
    case (op)
      2'b00:   begin u = a - b - c; s = sa - sb - sc; end
      2'b01:   begin u = a - b + c; s = sa - sb + sc; end
      2'b10:   begin u = a + b - c; s = sa + sb - sc; end
      default: begin u = a + b + c; s = sa + sb + sc; end
    endcase
    e.r    = 8'(u & 255);
    e.wrap = (u < 0) || (u > 255);
    e.ovf  = (s < -128) || (s > 127);
    return e;
  endfunction

  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready && !clr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_r", int'(out_r), int'(e.r));
        chk("res_wrap", int'(out_wrap), int'(e.wrap));
`ifdef OVF_FLAG_EN
        chk("res_ovf", int'(out_ovf), int'(e.ovf));
`endif
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [1:0] op, input bit gaps);
    int n;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_data  = d;
    in_op    = op;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_set(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [1:0] op, input bit gaps);
    send_beat(a, op, gaps);
    send_beat(b, 2'($urandom_range(0, 3)), gaps);
    exp_q.push_back(model(int'(a), int'(b), int'(c), op));
    send_beat(c, 2'($urandom_range(0, 3)), gaps);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("out_valid_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_out_wrap", int'(out_wrap), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    tick();

    // 10,3,2 op 11 with two-edge latency after the C beat
    out_ready = 1'b1;
    send_set(8'd10, 8'd3, 8'd2, 2'b11, 0);
    chk("lat_edge0", int'(out_valid), 0);
    tick();
    chk("lat_edge1", int'(out_valid), 0);
    chk("exec_in_ready", int'(in_ready), 0);
    tick();
    chk("lat_edge2", int'(out_valid), 1);
    chk("r_10_3_2_add", int'(out_r), 15);
    tick();

    send_set(8'd1, 8'd2, 8'd3, 2'b00, 1);
    wait_valid();
    chk("r_1_2_3_sub", int'(out_r), 252);
    chk("wrap_neg", int'(out_wrap), 1);
    tick();
    send_set(8'd200, 8'd100, 8'd50, 2'b11, 1);
    wait_valid();
    chk("r_200_100_50", int'(out_r), 94);
    chk("wrap_pos", int'(out_wrap), 1);
    tick();

    // Backpressure: result must hold steady for five cycles
    out_ready = 1'b0;
    send_set(8'd10, 8'd3, 8'd2, 2'b00, 0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("hold_r", int'(out_r), 5);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("released_valid", int'(out_valid), 0);
    chk("released_in_ready", int'(in_ready), 1);

    // Asynchronous reset after A and B
    send_beat(8'd50, 2'b11, 0);
    send_beat(8'd60, 2'b11, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_r", int'(out_r), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_valid", int'(out_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_set(8'd7, 8'd1, 8'd1, 2'b10, 0);
    wait_valid();
    chk("r_after_reset", int'(out_r), 7);
    tick();

    // clr in CAP_C drops the concurrent beat
    send_beat(8'd9, 2'b11, 0);
    send_beat(8'd9, 2'b11, 0);
    in_data = 8'd9; in_valid = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_cap_c_in_ready", int'(in_ready), 1);
    send_set(8'd4, 8'd4, 8'd4, 2'b01, 0);
    wait_valid();
    chk("r_after_clr", int'(out_r), 4);
    tick();

    // clr while a result is held discards it
    out_ready = 1'b0;
    send_beat(8'd1, 2'b11, 0);
    send_beat(8'd1, 2'b11, 0);
    send_beat(8'd1, 2'b11, 0);
    wait_valid();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_hold_valid", int'(out_valid), 0);
    chk("clr_hold_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;

`ifdef OVF_FLAG_EN
    send_set(8'd100, 8'd100, 8'd0, 2'b11, 0);
    wait_valid();
    chk("ovf_r", int'(out_r), 200);
    chk("ovf_wrap", int'(out_wrap), 0);
    chk("ovf_set", int'(out_ovf), 1);
    tick();
    send_set(8'd10, 8'd3, 8'd2, 2'b11, 0);
    wait_valid();
    chk("ovf_clear", int'(out_ovf), 0);
    tick();
`endif

    // Random sets with random gaps and random backpressure
    rdy_rand = 1;
    for (int i = 0; i < 40; i++) begin
      send_set(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1);
    end
    rdy_rand = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
    chk("drain_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/three_op_sequencer.md
THREE_OP_SEQUENCER -- requirements
Module: three_op_sequencer

Interface
REQ-001 Parameter: none; data width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state rises on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 clr  input  1  synchronous abort; discards partial operand set.
REQ-005 in_valid  input  1  in_data beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_data  input  8  operand byte, unsigned.
REQ-008 in_op  input  2  opcode, sampled only on the A beat.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_r  output  8  result, low 8 bits of exact result.
REQ-012 out_wrap  output  1  exact unsigned result outside 0..255.
REQ-013 out_ovf  output  1  signed overflow flag (present only with OVF_FLAG_EN).

Function
REQ-014 Beat accepted when in_valid and in_ready both high on a posedge.
REQ-015 FSM states SHALL be CAP_A, CAP_B, CAP_C, EXEC, HOLD; reset state CAP_A.
REQ-016 CAP_A: accept beat -> latch A and op, go CAP_B; CAP_B: latch B, go CAP_C; CAP_C: latch C, go EXEC.
REQ-017 in_ready SHALL be high exactly in CAP_A, CAP_B, CAP_C; low in EXEC and HOLD.
REQ-018 EXEC: register result and flags, go HOLD unconditionally (one cycle).
REQ-019 HOLD: out_valid high; on out_ready go CAP_A; out_r/out_wrap/out_ovf stable while out_valid and not out_ready.
REQ-020 Latency: C beat accepted at edge N -> out_valid high after edge N+2.
REQ-021 Opcode: 00 A-B-C, 01 A-B+C, 10 A+B-C, 11 A+B+C.
REQ-022 Exact result SHALL be computed in 10-bit signed arithmetic with A, B, C zero-extended; out_r = bits [7:0].
REQ-023 out_wrap = 1 iff exact result < 0 or > 255.
REQ-024 No beat accepted in CAP_A..CAP_C without in_valid; FSM waits indefinitely.
REQ-025 clr high: FSM -> CAP_A, out_valid -> 0 next edge, from any state; clr overrides a same-cycle beat or out_ready.
REQ-026 out_valid SHALL be registered; in_ready SHALL be a pure decode of state.

Reset
REQ-027 rst_n low: state CAP_A, out_valid 0, out_r 0, out_wrap 0, out_ovf 0, operand registers 0, immediately and asynchronously.
REQ-028 Reset mid-operation discards partial operands and any pending result; first beat after release is an A beat.

Configuration
REQ-029 Macro OVF_FLAG_EN defined: out_ovf port exists; out_ovf = 1 iff exact result with A, B, C read as signed 8-bit lies outside -128..127.
REQ-030 OVF_FLAG_EN undefined: out_ovf port and its logic absent; all other behaviour identical.

Structure
REQ-031 Shared package three_op_pkg SHALL hold the opcode enum (OP_SUB_SUB, OP_SUB_ADD, OP_ADD_SUB, OP_ADD_ADD) and FSM state typedef.
REQ-032 Arithmetic SHALL be one combinational sub-module three_op_alu (A, B, C, op -> r, wrap, ovf); FSM and registers in three_op_sequencer.

Verification
REQ-033 Beats 10,3,2 with op 11, out_ready high -> out_r 15, out_wrap 0, out_valid two edges after C beat.
REQ-034 Beats 1,2,3 with op 00 -> out_r 252, out_wrap 1; beats 200,100,50 op 11 -> out_r 94, out_wrap 1.
REQ-035 Beats 10,3,2 op 00 with out_ready low 5 cycles -> out_r 5 held stable, in_ready low throughout, released on out_ready.
REQ-036 rst_n pulse after A and B beats -> outputs 0; next beats 7,1,1 op 10 -> out_r 7.
REQ-037 clr asserted in CAP_C with in_valid high -> beat dropped, state CAP_A; following set 4,4,4 op 01 -> out_r 4.
REQ-038 OVF_FLAG_EN defined: 100,100,0 op 11 -> out_r 200, out_wrap 0, out_ovf 1; 10,3,2 op 11 -> out_ovf 0.
